battle_master_ctrl: RTL and testbench

Turn sequencer on player A's (master) board. It synchronizes both players' buttons and runs the setup → alternate attacks → win/lose game flow. It drives the load/mode/clear controls into both 8-bit datapaths: A's local datapath, and B's slave datapath over the inter-board cable. It also selects the status word each player's seven-segment display shows. The block holds no ship or attack data; it only reads per-side validity and alive flags.

---
 rtl/battle_pkg.sv | 31 +++
 rtl/battle_master_ctrl_if.sv | 24 ++
 rtl/btn_sync_edge.sv | 45 ++++
 rtl/battle_master_ctrl.sv | 173 +++++++++++++++++
 tb/tb_battle_master_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/battle_pkg.sv
// Shared game-flow definitions for the battleship master sequencer, Words2 and the slave top.
// The state enum gives the encoding; the word codes index the seven-segment status words.
package battle_pkg;

  typedef enum logic [3:0] {
    GS_CLR      = 4'd0,
    GS_PLACE    = 4'd1,
    GS_A_TURN   = 4'd2,
    GS_A_LOAD   = 4'd3,
    GS_A_SETTLE = 4'd4,
    GS_B_TURN   = 4'd5,
    GS_B_LOAD   = 4'd6,
    GS_B_SETTLE = 4'd7,
    GS_A_WIN    = 4'd8,
    GS_B_WIN    = 4'd9
  } game_state_t;

  localparam logic [2:0] PLACE  = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] ATTACK = 3'd2;
  localparam logic [2:0] BAD    = 3'd3;
  localparam logic [2:0] WIN    = 3'd4;
  localparam logic [2:0] LOSE   = 3'd5;
  localparam logic [2:0] BLANK  = 3'd7;

  // Word for the side whose turn it is: flags a rejected attack selection.
  function automatic logic [2:0] attack_word(input logic bad);
    return bad ? BAD : ATTACK;
  endfunction

endpackage

// File: rtl/battle_master_ctrl_if.sv
// Button, checker and datapath-control signals between the turn sequencer and both boards.
// master = the sequencer, slave = the buttons/datapaths it talks to.
interface battle_master_ctrl_if;
  import battle_pkg::*;

  logic       btn1a, btn3a, btn1b, btn3b;
  logic       oka, okb;
  logic       liva, livb;
  logic       st;
  logic       game_clr;
  logic       ldr2a, ldr2b;
  logic [2:0] dispa, dispb;
  logic       turn_b;

  modport master (
    input  btn1a, btn3a, btn1b, btn3b, oka, okb, liva, livb,
    output st, game_clr, ldr2a, ldr2b, dispa, dispb, turn_b
  );

  modport slave (
    output btn1a, btn3a, btn1b, btn3b, oka, okb, liva, livb,
    input  st, game_clr, ldr2a, ldr2b, dispa, dispb, turn_b
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Raw button synchronizer followed by a registered rising-edge detector.
// A held button yields a single one-cycle pulse, SYNC_STAGES+1 cycles after the rise.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!clr_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= btn;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!clr_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      prev_reg  <= sync_reg[SYNC_STAGES-1];
      pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/battle_master_ctrl.sv
// Turn sequencer on player A's board: setup, alternating attacks and win/lose for both sides.
// Drives load/mode/clear into both datapaths and picks each side's status word.
module battle_master_ctrl
  import battle_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                        clk,
  input  logic                        clr_n,
  battle_master_ctrl_if.master        bus
);

  localparam logic [3:0] S_CLR      = GS_CLR;
  localparam logic [3:0] S_PLACE    = GS_PLACE;
  localparam logic [3:0] S_A_TURN   = GS_A_TURN;
  localparam logic [3:0] S_A_LOAD   = GS_A_LOAD;
  localparam logic [3:0] S_A_SETTLE = GS_A_SETTLE;
  localparam logic [3:0] S_B_TURN   = GS_B_TURN;
  localparam logic [3:0] S_B_LOAD   = GS_B_LOAD;
  localparam logic [3:0] S_B_SETTLE = GS_B_SETTLE;
  localparam logic [3:0] S_A_WIN    = GS_A_WIN;
  localparam logic [3:0] S_B_WIN    = GS_B_WIN;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

  // Pulse order: c1a, c3a, c1b, c3b.
  logic [3:0] raw_btn;
  logic [3:0] btn_pulse;
  logic       c1a, c3a, c1b, c3b;

  assign raw_btn = {bus.btn3b, bus.btn1b, bus.btn3a, bus.btn1a};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .clr_n (clr_n),
        .btn   (raw_btn[gi]),
        .pulse (btn_pulse[gi])
      );
    end
  endgenerate

  assign {c3b, c1b, c3a, c1a} = btn_pulse;

  logic [3:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       ready_a_reg, ready_a_next, ready_b_reg, ready_b_next;
  logic       bad_a_reg, bad_a_next, bad_b_reg, bad_b_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ready_a_next = ready_a_reg;
    ready_b_next = ready_b_reg;
    bad_a_next   = bad_a_reg;
    bad_b_next   = bad_b_reg;
    case (state_reg)
      S_CLR: begin
        state_next   = S_PLACE;
        cnt_next     = 4'd0;
        ready_a_next = 1'b0;
        ready_b_next = 1'b0;
        bad_a_next   = 1'b0;
        bad_b_next   = 1'b0;
      end
      S_PLACE: begin
        ready_a_next = ready_a_reg | c1a;
        ready_b_next = ready_b_reg | c1b;
        if (ready_a_next && ready_b_next) begin
          state_next   = S_A_TURN;
          ready_a_next = 1'b0;
          ready_b_next = 1'b0;
        end
      end
      S_A_TURN: if (c1a) begin
        bad_a_next = ~bus.oka;
        if (bus.oka) state_next = S_A_LOAD;
      end
      S_A_LOAD: begin
        state_next = S_A_SETTLE;
        cnt_next   = SETTLE_INIT;
      end
      S_A_SETTLE: begin
        if (cnt_reg == 4'd0) state_next = bus.livb ? S_B_TURN : S_A_WIN;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_B_TURN: if (c1b) begin
        bad_b_next = ~bus.okb;
        if (bus.okb) state_next = S_B_LOAD;
      end
      S_B_LOAD: begin
        state_next = S_B_SETTLE;
        cnt_next   = SETTLE_INIT;
      end
      S_B_SETTLE: begin
        if (cnt_reg == 4'd0) state_next = bus.liva ? S_A_TURN : S_B_WIN;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_A_WIN, S_B_WIN: ;
      default: state_next = S_CLR;
    endcase
    // A new-game press beats any confirm arriving in the same cycle.
    if (c3a || c3b) begin
      state_next   = S_CLR;
      ready_a_next = 1'b0;
      ready_b_next = 1'b0;
      bad_a_next   = 1'b0;
      bad_b_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg   <= S_CLR;
      cnt_reg     <= 4'd0;
      ready_a_reg <= 1'b0;
      ready_b_reg <= 1'b0;
      bad_a_reg   <= 1'b0;
      bad_b_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ready_a_reg <= ready_a_next;
      ready_b_reg <= ready_b_next;
      bad_a_reg   <= bad_a_next;
      bad_b_reg   <= bad_b_next;
    end
  end

  // Bad flags are already clear in LOAD/SETTLE, so the turn word stays ATTACK there.
  logic [2:0] dispa_w, dispb_w;

  always_comb begin
    dispa_w = BLANK;
    dispb_w = BLANK;
    case (state_reg)
      S_PLACE: begin
        dispa_w = ready_a_reg ? WAIT : PLACE;
        dispb_w = ready_b_reg ? WAIT : PLACE;
      end
      S_A_TURN, S_A_LOAD, S_A_SETTLE: begin
        dispa_w = attack_word(bad_a_reg);
        dispb_w = WAIT;
      end
      S_B_TURN, S_B_LOAD, S_B_SETTLE: begin
        dispa_w = WAIT;
        dispb_w = attack_word(bad_b_reg);
      end
      S_A_WIN: begin
        dispa_w = WIN;
        dispb_w = LOSE;
      end
      S_B_WIN: begin
        dispa_w = LOSE;
        dispb_w = WIN;
      end
      default: ;
    endcase
  end

  assign bus.game_clr = (state_reg == S_CLR);
  assign bus.st       = (state_reg != S_CLR) && (state_reg != S_PLACE);
  assign bus.ldr2a    = (state_reg == S_A_LOAD);
  assign bus.ldr2b    = (state_reg == S_B_LOAD);
  assign bus.turn_b   = (state_reg == S_B_TURN) || (state_reg == S_B_LOAD) ||
                        (state_reg == S_B_SETTLE);
  assign bus.dispa    = dispa_w;
  assign bus.dispb    = dispb_w;

endmodule

// File: tb/tb_battle_master_ctrl.sv
// Bench for battle_master_ctrl: directed game scenarios plus random button traffic,
// every cycle compared against a per-player game model.
module tb_battle_master_ctrl;
  import battle_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE_CYC  = 4;

  localparam int M_CLEAR = 0;
  localparam int M_PLACE = 1;
  localparam int M_TURN  = 2;
  localparam int M_WON   = 3;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  // Stimulus, indexed by player (0 = A, 1 = B).
  logic raw1 [2];
  logic raw3 [2];
  logic ok   [2];
  logic liv  [2];

  battle_master_ctrl_if bif ();

  assign bif.btn1a = raw1[0];
  assign bif.btn1b = raw1[1];
  assign bif.btn3a = raw3[0];
  assign bif.btn3b = raw3[1];
  assign bif.oka   = ok[0];
  assign bif.okb   = ok[1];
  assign bif.liva  = liv[0];
  assign bif.livb  = liv[1];

  battle_master_ctrl #(.SYNC_STAGES(SYNC_STAGES), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input int actual, input int expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Game model: phase, whose turn, cycles since the attack load (-1 = awaiting confirm).
  logic [7:0] hist1 [2];
  logic [7:0] hist3 [2];
  int  mode, player, winner, age;
  bit  rdy [2];
  bit  bad [2];

  task automatic model_step();
    bit c1 [2];
    bit c3 [2];
    for (int p = 0; p < 2; p++) begin
      if (!clr_n) begin
        hist1[p] = 8'd0;
        hist3[p] = 8'd0;
      end else begin
        hist1[p] = {hist1[p][6:0], raw1[p]};
        hist3[p] = {hist3[p][6:0], raw3[p]};
      end
      c1[p] = hist1[p][SYNC_STAGES+1] & ~hist1[p][SYNC_STAGES+2];
      c3[p] = hist3[p][SYNC_STAGES+1] & ~hist3[p][SYNC_STAGES+2];
    end
    if (!clr_n || c3[0] || c3[1]) begin
      mode = M_CLEAR;
      rdy[0] = 0; rdy[1] = 0; bad[0] = 0; bad[1] = 0;
      player = 0; age = -1;
    end else begin
      case (mode)
        M_CLEAR: mode = M_PLACE;
        M_PLACE: begin
          rdy[0] |= c1[0];
          rdy[1] |= c1[1];
          if (rdy[0] && rdy[1]) begin
            mode = M_TURN; player = 0; age = -1;
            rdy[0] = 0; rdy[1] = 0;
          end
        end
        M_TURN: begin
          if (age < 0) begin
            if (c1[player]) begin
              bad[player] = !ok[player];
              if (ok[player]) age = 0;
            end
          end else if (age == SETTLE_CYC) begin
            if (!liv[1-player]) begin
              mode = M_WON; winner = player;
            end else begin
              player = 1 - player; age = -1;
            end
          end else begin
            age++;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic int exp_word(input int p);
    case (mode)
      M_PLACE: return rdy[p] ? int'(WAIT) : int'(PLACE);
      M_TURN:  return (p != player) ? int'(WAIT) : (bad[p] ? int'(BAD) : int'(ATTACK));
      M_WON:   return (p == winner) ? int'(WIN) : int'(LOSE);
      default: return int'(BLANK);
    endcase
  endfunction

  // Current stimulus is what the next rising edge samples.
  task automatic tick();
    model_step();
    @(negedge clk);
    check_val("game_clr", int'(bif.game_clr), int'(mode == M_CLEAR));
    check_val("st",       int'(bif.st),       int'(mode == M_TURN || mode == M_WON));
    check_val("ldr2a",    int'(bif.ldr2a),    int'(mode == M_TURN && player == 0 && age == 0));
    check_val("ldr2b",    int'(bif.ldr2b),    int'(mode == M_TURN && player == 1 && age == 0));
    check_val("turn_b",   int'(bif.turn_b),   int'(mode == M_TURN && player == 1));
    check_val("dispa",    int'(bif.dispa),    exp_word(0));
    check_val("dispb",    int'(bif.dispb),    exp_word(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int p, input bit is_new_game, input int hold);
    if (is_new_game) raw3[p] = 1'b1;
    else             raw1[p] = 1'b1;
    idle(hold);
    raw1[p] = 1'b0;
    raw3[p] = 1'b0;
  endtask

  task automatic place_both();
    press(0, 0, 2);
    idle(20);
    press(1, 0, 2);
    idle(6);
  endtask

  int hold1 [2];
  int hold3 [2];

  initial begin
    clr_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      raw1[p] = 0; raw3[p] = 0; ok[p] = 1; liv[p] = 1;
      hold1[p] = 0; hold3[p] = 0;
      rdy[p] = 0; bad[p] = 0; hist1[p] = 0; hist3[p] = 0;
    end
    mode = M_CLEAR; player = 0; winner = 0; age = -1;

    idle(3);
    clr_n = 1'b1;
    idle(3);
    $display("txn 1: reset held 3 cycles and released");

    place_both();
    $display("txn 2: both players placed, A on turn");

    ok[0] = 1'b0;
    press(0, 0, 2);
    idle(6);
    ok[0] = 1'b1;
    press(0, 0, 2);
    idle(SETTLE_CYC + 6);
    $display("txn 3: A rejected then accepted attack");

    press(1, 0, 2);
    idle(SETTLE_CYC + 6);
    $display("txn 4: B attack, back to A");

    liv[1] = 1'b0;
    press(0, 0, 2);
    idle(SETTLE_CYC + 6);
    liv[1] = 1'b1;
    press(0, 0, 2);
    press(1, 0, 2);
    idle(6);
    $display("txn 5: A wins, confirm presses ignored");

    press(0, 1, 2);
    idle(4);
    place_both();
    raw1[0] = 1'b1;
    raw3[1] = 1'b1;
    idle(2);
    raw1[0] = 1'b0;
    raw3[1] = 1'b0;
    idle(8);
    $display("txn 6: new-game press wins over simultaneous confirm");

    place_both();
    raw1[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      raw1[1] = ((i % 10) < 3);
      tick();
    end
    raw1[0] = 1'b0;
    raw1[1] = 1'b0;
    idle(10);
    $display("txn 7: held A confirm with B presses during A turn");

    clr_n = 1'b0;
    idle(2);
    clr_n = 1'b1;
    idle(3);
    $display("txn 8: mid-game reset");

    for (int n = 0; n < 6000; n++) begin
      clr_n = ($urandom_range(0, 1999) != 0);
      for (int p = 0; p < 2; p++) begin
        if (hold1[p] > 0) begin
          hold1[p]--; raw1[p] = 1'b1;
        end else begin
          raw1[p] = 1'b0;
          if ($urandom_range(0, 19) == 0) hold1[p] = $urandom_range(1, 30);
        end
        if (hold3[p] > 0) begin
          hold3[p]--; raw3[p] = 1'b1;
        end else begin
          raw3[p] = 1'b0;
          if ($urandom_range(0, 599) == 0) hold3[p] = $urandom_range(1, 10);
        end
        ok[p]  = ($urandom_range(0, 3) != 0);
        liv[p] = ($urandom_range(0, 9) != 0);
      end
      tick();
    end
    $display("txn 9: 6000 random cycles");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
